// File: rtl/trash_exec_ctrl.sv
// trash_exec_ctrl: program store, register file, data memory and the
// fetch/execute sequencer that drives the external 4-bit ALU.
module trash_exec_ctrl #(
    parameter int unsigned PROG_DEPTH = 8,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [14:0]                   prog_data,
    output logic [3:0]                    alu_opcode,
    output logic [3:0]                    alu_a,
    output logic [3:0]                    alu_b,
    input  logic [7:0]                    alu_res,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic                          busy,
    output logic                          retire
);
    localparam int unsigned PC_W   = $clog2(PROG_DEPTH);
    localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
    localparam int unsigned IW     = 15;
    localparam int unsigned DW     = 8;
    localparam int unsigned NREG   = 4;

    // Instruction word layout: f2 = {f2h, f2l}.
    typedef struct packed {
        logic [3:0] f2h;
        logic [3:0] f2l;
        logic [3:0] f1;
        logic [2:0] op;
    } instr_t;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_e;

    typedef enum logic [2:0] {
        OP_NOOP, OP_STORE, OP_CALC, OP_MEMSTORE,
        OP_MEMLOAD, OP_JUMP, OP_JUMPIF, OP_OUT
    } op_e;

    state_e                          state_q, state_d;
    logic [PC_W-1:0]                 pc_q, pc_d;
    logic [PC_W-1:0]                 load_ptr_q, load_ptr_d;
    instr_t                          ir_q, ir_d;
    logic [PROG_DEPTH-1:0][IW-1:0]   prog_q, prog_d;
    logic [NREG-1:0][DW-1:0]         regs_q, regs_d;
    logic [MEM_DEPTH-1:0][DW-1:0]    mem_q, mem_d;
    logic [3:0]                      alu_op_q, alu_op_d;
    logic [3:0]                      alu_a_q, alu_a_d;
    logic [3:0]                      alu_b_q, alu_b_d;
    logic [DW-1:0]                   out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic                            retire_q, retire_d;
    instr_t                          fetch_w;

    // State and datapath registers; reset clears all storage to NOOP/zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            load_ptr_q  <= '0;
            ir_q        <= '0;
            prog_q      <= '0;
            regs_q      <= '0;
            mem_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            retire_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            load_ptr_q  <= load_ptr_d;
            ir_q        <= ir_d;
            prog_q      <= prog_d;
            regs_q      <= regs_d;
            mem_q       <= mem_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            retire_q    <= retire_d;
        end
    end

    // Next-state, instruction execution and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_ptr_d  = load_ptr_q;
        ir_d        = ir_q;
        prog_d      = prog_q;
        regs_d      = regs_q;
        mem_d       = mem_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        retire_d    = 1'b0;
        fetch_w     = prog_q[pc_q];

        unique case (state_q)
            S_IDLE: begin
                if (prog_we) begin
                    prog_d[load_ptr_q] = prog_data;
                    load_ptr_d         = load_ptr_q + PC_W'(1);
                end
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (!run) begin
                    state_d    = S_IDLE;
                    pc_d       = '0;
                    load_ptr_d = '0;
                end else begin
                    ir_d     = fetch_w;
                    state_d  = S_EXEC;
                    // Two-cycle ops retire in the coming EXEC cycle.
                    retire_d = (fetch_w.op != 3'(OP_CALC));
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_q + PC_W'(1);
                case (op_e'(ir_q.op))
                    OP_NOOP: ;
                    OP_STORE:    regs_d[ir_q.f1[1:0]] = {ir_q.f2h, ir_q.f2l};
                    OP_CALC: begin
                        alu_op_d = ir_q.f1;
                        alu_a_d  = regs_q[ir_q.f2h[1:0]][7:4];
                        alu_b_d  = regs_q[ir_q.f2h[1:0]][3:0];
                        state_d  = S_WB;
                        retire_d = 1'b1;
                    end
                    OP_MEMSTORE: mem_d[MEM_AW'(ir_q.f1)] = {ir_q.f2h, ir_q.f2l};
                    OP_MEMLOAD:  regs_d[ir_q.f2h[1:0]] = mem_q[MEM_AW'(ir_q.f1)];
                    OP_JUMP:     pc_d = PC_W'(ir_q.f1);
                    OP_JUMPIF: begin
                        if (regs_q[ir_q.f2h[1:0]] == regs_q[ir_q.f2l[1:0]]) begin
                            pc_d = PC_W'(ir_q.f1);
                        end
                    end
                    OP_OUT: begin
                        out_data_d  = regs_q[ir_q.f1[1:0]];
                        out_valid_d = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                regs_d[ir_q.f2l[1:0]] = alu_res;
                state_d               = S_FETCH;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign alu_opcode = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign pc         = pc_q;
    assign busy       = busy_q;
    assign retire     = retire_q;

endmodule

// File: tb/tb_trash_exec_ctrl.sv
// Self-checking bench for trash_exec_ctrl: an instruction-level reference
// model retires one instruction per DUT retire pulse and checks the results.
module tb_trash_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        prog_we;
    logic [14:0] prog_data;
    logic [3:0]  alu_opcode, alu_a, alu_b;
    logic [7:0]  alu_res;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  pc;
    logic        busy, retire;

    trash_exec_ctrl #(.PROG_DEPTH(8), .MEM_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_data(prog_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .out_data(out_data), .out_valid(out_valid), .pc(pc), .busy(busy), .retire(retire)
    );

    always #5 clk = ~clk;

    // External ALU stand-in (op 0 is ADD).
    function automatic logic [7:0] bench_alu(input logic [3:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            4'd0:    return 8'(a) + 8'(b);
            4'd1:    return 8'(a) - 8'(b);
            4'd2:    return 8'(a) * 8'(b);
            default: return {a, b} ^ {op, op};
        endcase
    endfunction

    assign alu_res = bench_alu(alu_opcode, alu_a, alu_b);

    // Reference machine state.
    logic [14:0] m_prog [8];
    logic [7:0]  m_r    [4];
    logic [7:0]  m_mem  [16];
    int          m_pc, m_ptr;
    logic [7:0]  m_out;
    logic [3:0]  m_aop, m_a, m_b;
    logic [7:0]  out_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++)  m_prog[i] = '0;
        for (int i = 0; i < 4; i++)  m_r[i]    = '0;
        for (int i = 0; i < 16; i++) m_mem[i]  = '0;
        m_pc = 0; m_ptr = 0; m_out = '0; m_aop = '0; m_a = '0; m_b = '0;
    endfunction

    function automatic void model_write(input logic [14:0] w);
        m_prog[m_ptr] = w;
        m_ptr = (m_ptr + 1) % 8;
    endfunction

    // Executes the instruction at m_pc at ISA level.
    task automatic model_step(output bit is_out);
        logic [14:0] w;
        logic [3:0]  f1, f2h, f2l;
        logic [7:0]  f2;
        int          npc;
        w   = m_prog[m_pc];
        f1  = w[6:3];
        f2  = w[14:7];
        f2h = f2[7:4];
        f2l = f2[3:0];
        npc = (m_pc + 1) % 8;
        is_out = 1'b0;
        case (w[2:0])
            3'd1: m_r[int'(f1) % 4] = f2;
            3'd2: begin
                m_aop = f1;
                m_a   = m_r[int'(f2h) % 4][7:4];
                m_b   = m_r[int'(f2h) % 4][3:0];
                m_r[int'(f2l) % 4] = bench_alu(m_aop, m_a, m_b);
            end
            3'd3: m_mem[f1] = f2;
            3'd4: m_r[int'(f2h) % 4] = m_mem[f1];
            3'd5: npc = int'(f1) % 8;
            3'd6: if (m_r[int'(f2h) % 4] == m_r[int'(f2l) % 4]) npc = int'(f1) % 8;
            3'd7: begin
                m_out  = m_r[int'(f1) % 4];
                is_out = 1'b1;
                out_q.push_back(m_out);
            end
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"},        32'(pc), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_retire"},    32'(retire), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_alu_op"},    32'(alu_opcode), 0);
        check({tag, "_alu_a"},     32'(alu_a), 0);
        check({tag, "_alu_b"},     32'(alu_b), 0);
    endtask

    // Checks in the FETCH cycle that follows a retire.
    task automatic post_checks(input bit is_out);
        check("pc",        32'(pc), 32'(m_pc));
        check("out_valid", 32'(out_valid), 32'(is_out));
        check("out_data",  32'(out_data), 32'(m_out));
        check("alu_op",    32'(alu_opcode), 32'(m_aop));
        check("alu_a",     32'(alu_a), 32'(m_a));
        check("alu_b",     32'(alu_b), 32'(m_b));
    endtask

    task automatic load_words(input logic [14:0] ws[$]);
        foreach (ws[i]) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_data = ws[i];
            model_write(ws[i]);
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic load_random(input int n);
        logic [14:0] ws[$];
        logic [14:0] w;
        for (int i = 0; i < n; i++) begin
            w = 15'($urandom);
            if ($urandom_range(0, 3) == 0) w[2:0] = 3'd7;
            ws.push_back(w);
        end
        load_words(ws);
    endtask

    // Runs until n instructions retire, then drops run during the last one.
    task automatic run_program(input int n);
        int          retired = 0;
        int          cyc = 0;
        int          last = 0;
        int          len;
        bit          pending = 1'b0;
        bit          is_out = 1'b0;
        logic [14:0] w;
        @(negedge clk);
        run = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            w = 15'($urandom);
            prog_we   = 1'b1;
            prog_data = w;
            model_write(w);
        end else begin
            prog_we = 1'b0;
        end
        while (retired < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            prog_we   = 1'($urandom);
            prog_data = 15'($urandom);
            if (pending) begin
                post_checks(is_out);
                pending = 1'b0;
            end
            if (retire) begin
                len = (m_prog[m_pc][2:0] == 3'd2) ? 3 : 2;
                check("retire_gap", 32'(cyc - last), 32'(len));
                check("busy_run", 32'(busy), 1);
                last = cyc;
                model_step(is_out);
                pending = 1'b1;
                retired++;
                if (retired == n) begin
                    run     = 1'b0;
                    prog_we = 1'b0;
                end
            end
        end
        run     = 1'b0;
        prog_we = 1'b0;
        if (retired < n) check("timeout", 32'(retired), 32'(n));
        @(negedge clk);
        if (pending) post_checks(is_out);
        @(negedge clk);
        check("halt_busy", 32'(busy), 0);
        check("halt_pc",   32'(pc), 0);
        m_pc  = 0;
        m_ptr = 0;
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        run     = 1'b1;
        prog_we = 1'b0;
        repeat ($urandom_range(3, 15)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        run = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] dir_q[$];
        logic [7:0]  exp_out [3];
        rst_n = 1'b0; run = 1'b0; prog_we = 1'b0; prog_data = '0;
        model_reset();
        #12 check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // STORE/OUT, CALC ADD, MEMSTORE/MEMLOAD/OUT, JUMP 0.
        dir_q = '{15'h2D09, 15'h000F, 15'h0902, 15'h0017,
                  15'h3B9B, 15'h001C, 15'h0007, 15'h0005};
        load_words(dir_q);
        out_q.delete();
        run_program(8);
        exp_out[0] = 8'h5A; exp_out[1] = 8'h0F; exp_out[2] = 8'h77;
        check("dir_out_count", 32'(out_q.size()), 3);
        for (int i = 0; i < 3; i++) check("dir_out_val", 32'(out_q[i]), 32'(exp_out[i]));

        // JUMP 0 at pc=2 loops 0,1,2,0,...
        dir_q = '{15'h0000, 15'h0000, 15'h0005};
        load_words(dir_q);
        run_program(7);

        for (int t = 0; t < 12; t++) begin
            load_random($urandom_range(8, 11));
            run_program($urandom_range(10, 40));
            if (t == 5) reset_mid_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
